axi_lite_7seg_scan: RTL and testbench

- Parametrised AXI4-Lite slave driving a multiplexed common-anode seven-segment display bank.
- Successor to the fixed Nexys4-DDR 7-segment peripheral; adds:
  - configurable digit count and refresh rate
  - per-digit hex decode, decimal-point and blanking masks
  - 16-level brightness PWM and lamp test
- Sits behind the AXI interconnect as a memory-mapped peripheral; outputs go straight to board pins.

---
 rtl/axi_lite_7seg_scan_if.sv | 38 +++
 rtl/axi_lite_7seg_scan.sv | 217 +++++++++++++++++++++
 tb/tb_axi_lite_7seg_scan.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_7seg_scan_if.sv
// AXI4-Lite slave-side bundle for the seven-segment scanner.
// Master drives address/data/valid and response-ready; slave returns ready/valid/response.
interface axi_lite_7seg_scan_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_7seg_scan.sv
// AXI4-Lite register block driving a multiplexed common-anode 7-segment bank with PWM dimming.
// Pins are registered (1-cycle latency); one write and one read outstanding, each held until B/R ready.
module axi_lite_7seg_scan #(
  parameter int NUM_DIGITS         = 8,
  parameter int REFRESH_DIV        = 100000,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  axi_lite_7seg_scan_if.slave   s_axi,
  output logic [6:0]            SEG_N,
  output logic                  DP_N,
  output logic [NUM_DIGITS-1:0] AN_N
);

  localparam int              PRESC_W    = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [2:0]      IDX_MAX    = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]      DIGIT_MASK = 8'((16'd1 << NUM_DIGITS) - 16'd1);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACCEPT = 2'd1, R_DATA = 2'd2} rd_state_t;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] raddr;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic         ctrl_enable;
  logic         ctrl_lamp;
  logic [3:0]   ctrl_bright;
  logic [31:0]  digits;
  logic [7:0]   dp_mask;
  logic [7:0]   blank_mask;

  logic [PRESC_W-1:0] presc;
  logic [2:0]         scan_idx;
  logic [3:0]         pwm;

  logic         wr_en;
  logic [3:0]   cur_nib;
  logic [7:0]   an_full;
  logic         lit;
  logic         unused;

  assign waddr  = s_axi.awaddr;
  assign raddr  = s_axi.araddr;
  assign unused = ^{s_axi.awprot, s_axi.arprot, waddr[1:0], raddr[1:0]};

  // Write channel FSM: ready pulses in ACCEPT, which is also the register-update edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:   if (s_axi.awvalid && s_axi.wvalid) w_next = W_ACCEPT;
      W_ACCEPT: w_next = W_RESP;
      W_RESP:   if (s_axi.bready) w_next = W_IDLE;
      default:  w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state)
      W_ACCEPT: begin
        s_axi.awready = 1'b1;
        s_axi.wready  = 1'b1;
      end
      W_RESP:   s_axi.bvalid = 1'b1;
      default:  ;
    endcase
  end

  assign s_axi.bresp = 2'b00;
  assign wr_en = (w_state == W_ACCEPT);

  // Read channel FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (s_axi.arvalid) r_next = R_ACCEPT;
      R_ACCEPT: r_next = R_DATA;
      R_DATA:   if (s_axi.rready) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    case (r_state)
      R_ACCEPT: s_axi.arready = 1'b1;
      R_DATA:   s_axi.rvalid  = 1'b1;
      default:  ;
    endcase
  end

  assign s_axi.rresp = 2'b00;
  assign s_axi.rdata = rdata_q;

  // Register file; DP/BLANK bits beyond the populated digits never stick.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_enable <= 1'b1;
      ctrl_lamp   <= 1'b0;
      ctrl_bright <= 4'hF;
      digits      <= 32'd0;
      dp_mask     <= 8'd0;
      blank_mask  <= 8'd0;
    end else if (wr_en) begin
      case (waddr[4:2])
        3'd0: if (s_axi.wstrb[0]) begin
          ctrl_enable <= s_axi.wdata[0];
          ctrl_lamp   <= s_axi.wdata[1];
          ctrl_bright <= s_axi.wdata[7:4];
        end
        3'd1: for (int k = 0; k < 4; k++) begin
          if (s_axi.wstrb[k]) digits[8*k +: 8] <= s_axi.wdata[8*k +: 8];
        end
        3'd2: if (s_axi.wstrb[0]) dp_mask    <= s_axi.wdata[7:0] & DIGIT_MASK;
        3'd3: if (s_axi.wstrb[0]) blank_mask <= s_axi.wdata[7:0] & DIGIT_MASK;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (raddr[4:2])
      3'd0: rd_mux[7:0]  = {ctrl_bright, 2'b00, ctrl_lamp, ctrl_enable};
      3'd1: rd_mux[31:0] = digits;
      3'd2: rd_mux[7:0]  = dp_mask;
      3'd3: rd_mux[7:0]  = blank_mask;
      3'd4: begin
        rd_mux[2:0] = scan_idx;
        rd_mux[8]   = ctrl_enable;
      end
      default: rd_mux = '0;
    endcase
  end

  // Captured on the address handshake, so a same-edge write is not yet visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 rdata_q <= '0;
    else if (r_state == R_ACCEPT) rdata_q <= rd_mux;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc    <= '0;
      scan_idx <= 3'd0;
      pwm      <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
      if (presc == PRESC_MAX) begin
        presc    <= '0;
        scan_idx <= (scan_idx == IDX_MAX) ? 3'd0 : scan_idx + 3'd1;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign cur_nib = digits[{scan_idx, 2'b00} +: 4];
  assign an_full = 8'd1 << scan_idx;
  assign lit     = ctrl_enable && (ctrl_lamp || !blank_mask[scan_idx]) && (pwm <= ctrl_bright);

  // A single registered update per index change keeps AN_N one-hot-or-zero.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      SEG_N <= 7'h7F;
      DP_N  <= 1'b1;
      AN_N  <= '1;
    end else begin
      SEG_N <= ctrl_lamp ? 7'h00 : hex7(cur_nib);
      DP_N  <= ctrl_lamp ? 1'b0 : ~dp_mask[scan_idx];
      AN_N  <= lit ? ~an_full[NUM_DIGITS-1:0] : '1;
    end
  end

endmodule

// File: tb/tb_axi_lite_7seg_scan.sv
// Directed bench for axi_lite_7seg_scan: an 8-digit and a 3-digit instance, both with REFRESH_DIV=4.
module tb_axi_lite_7seg_scan;
  localparam int RD = 4;

  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  axi_lite_7seg_scan_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi1 ();
  axi_lite_7seg_scan_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi2 ();

  logic [6:0] seg1, seg2;
  logic       dp1, dp2;
  logic [7:0] an1;
  logic [2:0] an2;

  axi_lite_7seg_scan #(.NUM_DIGITS(8), .REFRESH_DIV(RD)) dut1 (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi1), .SEG_N(seg1), .DP_N(dp1), .AN_N(an1));
  axi_lite_7seg_scan #(.NUM_DIGITS(3), .REFRESH_DIV(RD)) dut2 (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(axi2), .SEG_N(seg2), .DP_N(dp2), .AN_N(an2));

  logic        sel;
  logic [4:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  assign axi1.awaddr = awaddr;  assign axi2.awaddr = awaddr;
  assign axi1.araddr = araddr;  assign axi2.araddr = araddr;
  assign axi1.wdata  = wdata;   assign axi2.wdata  = wdata;
  assign axi1.wstrb  = wstrb;   assign axi2.wstrb  = wstrb;
  assign axi1.awprot = 3'b000;  assign axi2.awprot = 3'b000;
  assign axi1.arprot = 3'b000;  assign axi2.arprot = 3'b000;
  assign axi1.awvalid = awvalid && !sel;  assign axi2.awvalid = awvalid && sel;
  assign axi1.wvalid  = wvalid  && !sel;  assign axi2.wvalid  = wvalid  && sel;
  assign axi1.bready  = bready  && !sel;  assign axi2.bready  = bready  && sel;
  assign axi1.arvalid = arvalid && !sel;  assign axi2.arvalid = arvalid && sel;
  assign axi1.rready  = rready  && !sel;  assign axi2.rready  = rready  && sel;

  logic        awready_m, bvalid_m, arready_m, rvalid_m;
  logic [1:0]  bresp_m, rresp_m;
  logic [31:0] rdata_m;
  assign awready_m = sel ? axi2.awready : axi1.awready;
  assign bvalid_m  = sel ? axi2.bvalid  : axi1.bvalid;
  assign bresp_m   = sel ? axi2.bresp   : axi1.bresp;
  assign arready_m = sel ? axi2.arready : axi1.arready;
  assign rvalid_m  = sel ? axi2.rvalid  : axi1.rvalid;
  assign rresp_m   = sel ? axi2.rresp   : axi1.rresp;
  assign rdata_m   = sel ? axi2.rdata   : axi1.rdata;

  // Clock edges since reset release; the scan position is derived from it.
  int cyc;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name, input int waited);
    total_cnt++;
    $display("FAIL %s: waited %0d cycles, required fewer than 20", name, waited);
  endtask

  task automatic axi_write(input logic s, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    @(negedge ACLK);
    sel = s; awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready_m && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout("awready", n);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!bvalid_m && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("bvalid", n);
    else chk("bresp", 32'(bresp_m), 32'd0);
    @(posedge ACLK); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic s, input logic [4:0] addr, input int rdly,
                          output logic [31:0] data, output int hs);
    int n;
    bit held_ok;
    data = '0; hs = 0; held_ok = 1'b1;
    @(negedge ACLK);
    sel = s; araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready_m && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout("arready", n);
      arvalid = 1'b0;
      return;
    end
    hs = cyc;
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    @(negedge ACLK);
    n = 0;
    while (!rvalid_m && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) begin
      timeout("rvalid", n);
      return;
    end
    data = rdata_m;
    chk("rresp", 32'(rresp_m), 32'd0);
    for (int k = 0; k < rdly; k++) begin
      @(negedge ACLK);
      if (!rvalid_m || rdata_m !== data) held_ok = 1'b0;
    end
    if (rdly > 0) chk("rdata_hold", 32'(held_ok), 32'd1);
    rready = 1'b1;
    @(posedge ACLK); #1;
    rready = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    @(negedge ACLK);
    while (!(cyc >= 1 && ((cyc - 1) % RD) == 0 && (((cyc - 1) / RD) % 8) == s) && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 200) timeout("slot_align", n);
  endtask

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] blank;
    int         slot;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
    bit         seg_dc;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  logic [31:0] d;
  int hs, bad, n, m;
  logic [7:0] cur_ctrl, cur_blank;
  logic [2:0] exp3;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion before 500000");
    $fatal(1);
  end

  initial begin
    // DIGITS=0x0123ABCF, DP=0x81
    vecs[0]  = '{8'hF1, 8'h00, 0, 7'h0E, 1'b0, 8'hFE, 1'b0};
    vecs[1]  = '{8'hF1, 8'h00, 1, 7'h46, 1'b1, 8'hFD, 1'b0};
    vecs[2]  = '{8'hF1, 8'h00, 2, 7'h03, 1'b1, 8'hFB, 1'b0};
    vecs[3]  = '{8'hF1, 8'h00, 3, 7'h08, 1'b1, 8'hF7, 1'b0};
    vecs[4]  = '{8'hF1, 8'h00, 4, 7'h30, 1'b1, 8'hEF, 1'b0};
    vecs[5]  = '{8'hF1, 8'h00, 5, 7'h24, 1'b1, 8'hDF, 1'b0};
    vecs[6]  = '{8'hF1, 8'h00, 6, 7'h79, 1'b1, 8'hBF, 1'b0};
    vecs[7]  = '{8'hF1, 8'h00, 7, 7'h40, 1'b0, 8'h7F, 1'b0};
    vecs[8]  = '{8'hF3, 8'h04, 2, 7'h00, 1'b0, 8'hFB, 1'b0};
    vecs[9]  = '{8'hF3, 8'h04, 3, 7'h00, 1'b0, 8'hF7, 1'b0};
    vecs[10] = '{8'hF1, 8'h04, 2, 7'h00, 1'b1, 8'hFF, 1'b1};
    vecs[11] = '{8'hF1, 8'h04, 3, 7'h08, 1'b1, 8'hF7, 1'b0};
    vecs[12] = '{8'hF1, 8'h04, 0, 7'h0E, 1'b0, 8'hFE, 1'b0};

    sel = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    ARESETN = 1'b1;
    #2 ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    chk("rst_an",      32'(an1), 32'hFF);
    chk("rst_seg",     32'(seg1), 32'h7F);
    chk("rst_dp",      32'(dp1), 32'h1);
    chk("rst_an_n3",   32'(an2), 32'h7);
    chk("rst_awready", 32'(axi1.awready), 32'h0);
    chk("rst_bvalid",  32'(axi1.bvalid), 32'h0);
    chk("rst_rvalid",  32'(axi1.rvalid), 32'h0);
    chk("rst_rdata",   axi1.rdata, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    axi_read(1'b0, 5'h00, 0, d, hs);
    chk("ctrl_reset", d, 32'h0000_00F1);

    axi_write(1'b0, 5'h04, 32'h0123_ABCF, 4'hF);
    axi_write(1'b0, 5'h08, 32'h0000_0081, 4'hF);
    axi_read(1'b0, 5'h04, 3, d, hs);
    chk("digits_rb", d, 32'h0123_ABCF);

    // Byte-lane write disables the display but the scan keeps moving.
    axi_write(1'b0, 5'h00, 32'h1234_5678, 4'h1);
    axi_read(1'b0, 5'h00, 0, d, hs);
    chk("ctrl_strb", d, 32'h0000_0070);
    axi_read(1'b0, 5'h10, 0, d, hs);
    chk("status_off_a", d, 32'((hs / RD) % 8));
    bad = 0;
    repeat (40) begin @(negedge ACLK); if (an1 !== 8'hFF) bad++; end
    chk("disabled_an_lit_cycles", 32'(bad), 32'd0);
    axi_read(1'b0, 5'h10, 0, d, hs);
    chk("status_off_b", d, 32'((hs / RD) % 8));

    axi_write(1'b0, 5'h00, 32'h0000_0031, 4'hF);
    bad = 0; n = 0;
    repeat (64) begin
      @(negedge ACLK);
      if (an1 !== 8'hFF) begin
        n++;
        if ($countones(~an1) != 1) bad++;
      end
    end
    chk("bright3_on_cycles", 32'(n), 32'd16);
    chk("bright3_not_onehot", 32'(bad), 32'd0);

    cur_ctrl = 8'h31; cur_blank = 8'h00;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].ctrl != cur_ctrl) begin
        axi_write(1'b0, 5'h00, {24'd0, vecs[i].ctrl}, 4'hF);
        cur_ctrl = vecs[i].ctrl;
      end
      if (vecs[i].blank != cur_blank) begin
        axi_write(1'b0, 5'h0C, {24'd0, vecs[i].blank}, 4'hF);
        cur_blank = vecs[i].blank;
      end
      wait_slot(vecs[i].slot);
      for (int c = 0; c < RD; c++) begin
        if (c > 0) @(negedge ACLK);
        if (!vecs[i].seg_dc) chk($sformatf("v%0d_c%0d_seg", i, c), 32'(seg1), 32'(vecs[i].seg));
        chk($sformatf("v%0d_c%0d_dp", i, c), 32'(dp1), 32'(vecs[i].dp));
        chk($sformatf("v%0d_c%0d_an", i, c), 32'(an1), 32'(vecs[i].an));
      end
    end

    wait_slot(7);
    repeat (RD - 1) @(negedge ACLK);
    chk("wrap_last_s7_an", 32'(an1), 32'h7F);
    @(negedge ACLK);
    chk("wrap_first_s0_an", 32'(an1), 32'hFE);

    // Three-digit instance.
    axi_write(1'b1, 5'h08, 32'h0000_00FF, 4'hF);
    axi_read(1'b1, 5'h08, 0, d, hs);
    chk("n3_dp_masked", d, 32'h0000_0007);
    bad = 0;
    repeat (24) begin
      @(negedge ACLK);
      m = ((cyc - 1) / RD) % 3;
      exp3 = ~(3'b001 << m);
      if (an2 !== exp3) bad++;
    end
    chk("n3_scan_mismatches", 32'(bad), 32'd0);
    axi_read(1'b1, 5'h10, 0, d, hs);
    chk("n3_status", d, 32'h100 | 32'((hs / RD) % 3));
    axi_write(1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF);
    axi_read(1'b1, 5'h18, 0, d, hs);
    chk("n3_unmapped_rd", d, 32'h0);
    axi_read(1'b1, 5'h00, 0, d, hs);
    chk("n3_ctrl_untouched", d, 32'h0000_00F1);
    axi_read(1'b1, 5'h04, 0, d, hs);
    chk("n3_digits_untouched", d, 32'h0);
    axi_read(1'b0, 5'h1C, 0, d, hs);
    chk("unmapped_1c_rd", d, 32'h0);

    // Reset while a write response is pending.
    axi_write(1'b0, 5'h0C, 32'h0, 4'hF);
    @(negedge ACLK);
    sel = 1'b0; awaddr = 5'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!awready_m && n < 20) begin @(negedge ACLK); n++; end
    if (n >= 20) timeout("rst_awready", n);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ACLK);
    chk("bvalid_pending", 32'(bvalid_m), 32'd1);
    chk("pre_reset_an_lit", 32'(an1 != 8'hFF), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_an",     32'(an1), 32'hFF);
    chk("mid_rst_seg",    32'(seg1), 32'h7F);
    chk("mid_rst_dp",     32'(dp1), 32'h1);
    chk("mid_rst_an_n3",  32'(an2), 32'h7);
    chk("mid_rst_bvalid", 32'(axi1.bvalid), 32'h0);
    chk("mid_rst_arready", 32'(axi1.arready), 32'h0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    bad = 0;
    repeat (10) begin @(negedge ACLK); if (axi1.bvalid || axi1.rvalid) bad++; end
    chk("no_stale_valid", 32'(bad), 32'd0);
    axi_read(1'b0, 5'h00, 0, d, hs);
    chk("post_rst_ctrl", d, 32'h0000_00F1);
    axi_read(1'b0, 5'h04, 0, d, hs);
    chk("post_rst_digits", d, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
